// File: rtl/clk_monitor_pkg.sv
// Shared types and helpers for the slow-clock period monitor.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package clk_monitor_pkg;

    // Monitor state: waiting for a first edge, collecting matches, or locked.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

    // |meas - nominal| <= tol without unsigned wrap: subtract the smaller
    // operand from the larger one before comparing.
    function automatic logic within_tol(input int unsigned meas,
                                        input int unsigned nominal,
                                        input int unsigned tol);
        if (meas >= nominal) begin
            return (meas - nominal) <= tol;
        end
        return (nominal - meas) <= tol;
    endfunction

endpackage

// File: rtl/clk_period_monitor_if.sv
// Signal bundle between the period monitor and whatever drives/observes it.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level or a one-cycle strobe.
//   sig_in       : square wave under test (asynchronous to clk)
//   rise_pulse   : one-cycle strobe per synchronized rising edge
//   fall_pulse   : one-cycle strobe per synchronized falling edge
//   half_period  : last measured edge-to-edge interval in clk cycles
//   period_valid : one-cycle strobe when half_period updates
//   locked       : high while the monitor is locked
//   timeout      : high from a missing-edge timeout until the next edge
interface clk_period_monitor_if #(
    parameter int CNT_W = 12
);
    logic             sig_in;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    // master: the side that supplies sig_in and consumes the status.
    modport master (
        output sig_in,
        input  rise_pulse, fall_pulse, half_period, period_valid, locked, timeout
    );

    // slave: the monitor itself.
    modport slave (
        input  sig_in,
        output rise_pulse, fall_pulse, half_period, period_valid, locked, timeout
    );
endinterface

// File: rtl/clk_period_monitor_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; d is sampled every cycle.
//   clk   : destination clock
//   reset : synchronous active-high, clears both flops
//   d     : asynchronous input level
//   q     : synchronized level
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures edge-to-edge intervals of a slow square wave, locks after a run of
// in-tolerance halves, flags a timeout when edges stop arriving.
// Latency: edge strobes 2 cycles after sig_in moves; period_valid 1 cycle after the edge strobe.
// Backpressure: none; sig_in is sampled every cycle and strobes are not held.
//   clk   : system clock, all logic on posedge
//   reset : synchronous active-high
//   mon   : slave side of clk_period_monitor_if (sig_in in, status out)
module clk_period_monitor
    import clk_monitor_pkg::*;
#(
    parameter int EXPECTED_HALF = 1000,
    parameter int TOL           = 2,
    parameter int LOCK_COUNT    = 4,
    parameter int TIMEOUT_COUNT = 4 * EXPECTED_HALF
) (
    input  logic                clk,
    input  logic                reset,
    clk_period_monitor_if.slave mon
);
    localparam int CNT_W = $clog2(TIMEOUT_COUNT + 1);
    localparam int STK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_COUNT);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TIMEOUT_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [STK_W-1:0] STK_LAST = STK_W'(LOCK_COUNT - 1);
    localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);

    logic             w_sync;
    logic             r_hist;
    logic             w_edge;
    logic             w_rise;
    logic             w_fall;
    logic             w_to_hit;
    logic             w_match;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half_period;
    logic [STK_W-1:0] r_streak;
    mon_state_t       r_state;
    logic             r_period_valid;
    logic             r_locked;
    logic             r_timeout;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (mon.sig_in),
        .q     (w_sync)
    );

    assign w_edge = w_sync ^ r_hist;
    assign w_rise = w_sync & ~r_hist;
    assign w_fall = ~w_sync & r_hist;

    // The counter is about to reach the limit this cycle; an edge in the
    // same cycle takes priority and turns it into a normal measurement.
    assign w_to_hit = !w_edge && (r_cnt == CNT_PRE);

    // Judged on the registered measurement during its period_valid cycle,
    // so state/locked move one cycle after period_valid.
    assign w_match = within_tol(32'(r_half_period), 32'(EXPECTED_HALF), 32'(TOL));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist         <= 1'b0;
            r_cnt          <= '0;
            r_half_period  <= '0;
            r_streak       <= '0;
            r_state        <= ST_IDLE;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_hist <= w_sync;

            // Interval counter: restarts at 1 after an edge, saturates at the limit.
            if (w_edge) begin
                r_cnt <= CNT_ONE;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            // The arming edge out of IDLE only starts the interval; it is not
            // a measurement because the previous edge is unknown.
            r_period_valid <= 1'b0;
            if (w_edge && (r_state != ST_IDLE)) begin
                r_half_period  <= r_cnt;
                r_period_valid <= 1'b1;
            end

            if (w_edge) begin
                r_timeout <= 1'b0;
            end else if (w_to_hit) begin
                r_timeout <= 1'b1;
            end

            if (w_to_hit) begin
                r_state  <= ST_IDLE;
                r_streak <= '0;
                r_locked <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                if (w_edge) begin
                    r_state <= ST_MEASURE;
                end
            end else if (r_period_valid) begin
                if (!w_match) begin
                    r_state  <= ST_MEASURE;
                    r_streak <= '0;
                    r_locked <= 1'b0;
                end else if (r_state == ST_MEASURE) begin
                    if (r_streak == STK_LAST) begin
                        r_state  <= ST_LOCKED;
                        r_streak <= '0;
                        r_locked <= 1'b1;
                    end else begin
                        r_streak <= r_streak + STK_ONE;
                    end
                end
            end
        end
    end

    assign mon.rise_pulse   = w_rise;
    assign mon.fall_pulse   = w_fall;
    assign mon.half_period  = r_half_period;
    assign mon.period_valid = r_period_valid;
    assign mon.locked       = r_locked;
    assign mon.timeout      = r_timeout;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor: two instances (TOL=0 and TOL=2) share sig_in.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_period_monitor;
    localparam int EH = 5;
    localparam int LC = 4;
    localparam int TC = 20;
    localparam int CW = $clog2(TC + 1);

    logic clk = 1'b0;
    logic reset;
    logic sig_in;

    always #5 clk = ~clk;

    clk_period_monitor_if #(.CNT_W(CW)) if_a ();
    clk_period_monitor_if #(.CNT_W(CW)) if_b ();

    assign if_a.sig_in = sig_in;
    assign if_b.sig_in = sig_in;

    clk_period_monitor #(.EXPECTED_HALF(EH), .TOL(0), .LOCK_COUNT(LC), .TIMEOUT_COUNT(TC)) dut_a (
        .clk(clk), .reset(reset), .mon(if_a.slave));
    clk_period_monitor #(.EXPECTED_HALF(EH), .TOL(2), .LOCK_COUNT(LC), .TIMEOUT_COUNT(TC)) dut_b (
        .clk(clk), .reset(reset), .mon(if_b.slave));

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // cyc is the index of the latest posedge; the model holds the values the
    // outputs must show in the cycle that follows it.
    int   cyc = 0;
    logic p0, p1, p2;        // sig_in as seen 1, 2 and 3 samples ago
    int   last_e;            // cycle of the latest edge (reset counts as one)
    logic m_pv, m_to;
    int   m_half;
    int   m_mode   [2];      // 0 idle, 1 measuring, 2 locked
    int   m_streak [2];
    logic m_lock   [2];
    int   tol_of   [2] = '{0, 2};

    task automatic model_step(input logic r, input logic v);
        logic e, hit, pv_n, ok;
        int   gap, dev;
        if (r) begin
            p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
            last_e = cyc;
            m_pv = 1'b0; m_to = 1'b0; m_half = 0;
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_streak[i] = 0; m_lock[i] = 1'b0;
            end
        end else begin
            e   = (p1 != p2);
            gap = (cyc - 1) - last_e;
            if (gap > TC) gap = TC;
            hit  = !e && (gap == TC - 1);
            pv_n = e && (m_mode[0] != 0);
            for (int i = 0; i < 2; i++) begin
                if (hit) begin
                    m_mode[i] = 0; m_streak[i] = 0;
                end else if (m_mode[i] == 0) begin
                    if (e) m_mode[i] = 1;
                end else if (m_pv) begin
                    dev = (m_half > EH) ? m_half - EH : EH - m_half;
                    ok  = dev <= tol_of[i];
                    if (!ok) begin
                        m_mode[i] = 1; m_streak[i] = 0;
                    end else if (m_mode[i] == 1) begin
                        m_streak[i]++;
                        if (m_streak[i] == LC) begin
                            m_mode[i] = 2; m_streak[i] = 0;
                        end
                    end
                end
                m_lock[i] = (m_mode[i] == 2);
            end
            if (e) m_to = 1'b0;
            else if (hit) m_to = 1'b1;
            if (pv_n) m_half = gap;
            m_pv = pv_n;
            if (e) last_e = cyc - 1;
            p2 = p1; p1 = p0; p0 = v;
        end
    endtask

    // Drive inputs, let one posedge pass, advance the model, stop at negedge.
    task automatic clk_step(input logic r, input logic v);
        reset  = r;
        sig_in = v;
        @(posedge clk);
        cyc++;
        model_step(r, v);
        @(negedge clk);
    endtask

    task automatic lock_up();
        clk_step(1'b1, 1'b0);
        clk_step(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) clk_step(1'b0, ((i / 5) % 2) == 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n_rise, n_pv;
        clk_step(1'b1, 1'b1);
        clk_step(1'b1, 1'b1);
        n_checks++;
        if ({if_a.rise_pulse, if_a.fall_pulse, if_a.period_valid, if_a.locked, if_a.timeout} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags_a got=%b want=00000",
                     {if_a.rise_pulse, if_a.fall_pulse, if_a.period_valid, if_a.locked, if_a.timeout});
        end
        n_checks++;
        if ({if_b.rise_pulse, if_b.fall_pulse, if_b.period_valid, if_b.locked, if_b.timeout} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags_b got=%b want=00000",
                     {if_b.rise_pulse, if_b.fall_pulse, if_b.period_valid, if_b.locked, if_b.timeout});
        end
        n_checks++;
        if (if_a.half_period !== CW'(0)) begin
            n_errors++;
            $display("FAIL reset_half got=%0d want=0", if_a.half_period);
        end
        n_rise = 0; n_pv = 0;
        for (int i = 0; i < 8; i++) begin
            clk_step(1'b0, 1'b1);
            if (if_a.rise_pulse) n_rise++;
            if (if_a.period_valid || if_b.period_valid) n_pv++;
        end
        n_checks++;
        if (n_rise != 1) begin
            n_errors++;
            $display("FAIL spurious_rise_count got=%0d want=1", n_rise);
        end
        n_checks++;
        if (n_pv != 0) begin
            n_errors++;
            $display("FAIL spurious_rise_pv got=%0d want=0", n_pv);
        end
    endtask

    task automatic test_edge_latency();
        int t0, rise_cyc, fall_cyc, n_rise, n_fall;
        for (int i = 0; i < 6; i++) clk_step(1'b0, 1'b0);
        t0 = cyc; rise_cyc = -1; fall_cyc = -1; n_rise = 0; n_fall = 0;
        for (int i = 0; i < 10; i++) begin
            clk_step(1'b0, i < 3);
            if (if_a.rise_pulse) begin n_rise++; rise_cyc = cyc; end
            if (if_a.fall_pulse) begin n_fall++; fall_cyc = cyc; end
        end
        n_checks++;
        if (n_rise != 1 || n_fall != 1) begin
            n_errors++;
            $display("FAIL pulse_counts got=%0d/%0d want=1/1", n_rise, n_fall);
        end
        n_checks++;
        if (rise_cyc - t0 != 2) begin
            n_errors++;
            $display("FAIL rise_latency got=%0d want=2", rise_cyc - t0);
        end
        n_checks++;
        if (fall_cyc - rise_cyc != 3) begin
            n_errors++;
            $display("FAIL fall_after_rise got=%0d want=3", fall_cyc - rise_cyc);
        end
    endtask

    task automatic test_lock();
        int pv_n, pv4_cyc, lock_cyc;
        pv_n = 0; pv4_cyc = -1; lock_cyc = -1;
        clk_step(1'b1, 1'b0);
        clk_step(1'b1, 1'b0);
        for (int i = 0; i < 60; i++) begin
            clk_step(1'b0, ((i / 5) % 2) == 0);
            if (if_a.period_valid) begin
                pv_n++;
                if (pv_n == 4) pv4_cyc = cyc;
                n_checks++;
                if (if_a.half_period !== CW'(EH)) begin
                    n_errors++;
                    $display("FAIL lock_half pv=%0d got=%0d want=%0d", pv_n, if_a.half_period, EH);
                end
            end
            if (if_a.locked && lock_cyc < 0) lock_cyc = cyc;
        end
        n_checks++;
        if (pv4_cyc < 0 || lock_cyc != pv4_cyc + 1) begin
            n_errors++;
            $display("FAIL lock_timing got=%0d want=%0d", lock_cyc, pv4_cyc + 1);
        end
        n_checks++;
        if (if_b.locked !== 1'b1) begin
            n_errors++;
            $display("FAIL lock_b got=%b want=1", if_b.locked);
        end
    endtask

    task automatic test_unlock();
        int lens [7] = '{8, 5, 5, 5, 5, 5, 5};
        int pv8_cyc, drop_b, drop_a, after8, pvr_cyc, relock;
        logic v;
        pv8_cyc = -1; drop_b = -1; drop_a = -1; after8 = 0; pvr_cyc = -1; relock = -1;
        v = sig_in;
        for (int h = 0; h < 7; h++) begin
            v = ~v;
            for (int j = 0; j < lens[h]; j++) begin
                clk_step(1'b0, v);
                if (if_b.period_valid) begin
                    if (pv8_cyc < 0 && if_b.half_period == CW'(8)) pv8_cyc = cyc;
                    else if (pv8_cyc >= 0) begin
                        after8++;
                        if (after8 == 4) pvr_cyc = cyc;
                    end
                end
                if (!if_b.locked && drop_b < 0) drop_b = cyc;
                if (!if_a.locked && drop_a < 0) drop_a = cyc;
                if (drop_b >= 0 && if_b.locked && relock < 0) relock = cyc;
            end
        end
        n_checks++;
        if (pv8_cyc < 0 || drop_b != pv8_cyc + 1) begin
            n_errors++;
            $display("FAIL unlock_drop_b got=%0d want=%0d", drop_b, pv8_cyc + 1);
        end
        n_checks++;
        if (pv8_cyc < 0 || drop_a != pv8_cyc + 1) begin
            n_errors++;
            $display("FAIL unlock_drop_a got=%0d want=%0d", drop_a, pv8_cyc + 1);
        end
        n_checks++;
        if (pvr_cyc < 0 || relock != pvr_cyc + 1) begin
            n_errors++;
            $display("FAIL relock_timing got=%0d want=%0d", relock, pvr_cyc + 1);
        end
    endtask

    task automatic test_timeout();
        int edge_cyc, to_cyc, lock_at_to, ec2, to_at_e, to_after, n_pv;
        logic v;
        edge_cyc = -1; to_cyc = -1; lock_at_to = -1;
        v = ~sig_in;
        for (int i = 0; i < 30; i++) begin
            clk_step(1'b0, v);
            if (if_a.rise_pulse || if_a.fall_pulse) edge_cyc = cyc;
            if (if_a.timeout && to_cyc < 0) begin
                to_cyc = cyc;
                lock_at_to = int'(if_a.locked) + int'(if_b.locked);
            end
        end
        n_checks++;
        if (edge_cyc < 0 || to_cyc - edge_cyc != TC) begin
            n_errors++;
            $display("FAIL timeout_delay got=%0d want=%0d", to_cyc - edge_cyc, TC);
        end
        n_checks++;
        if (lock_at_to != 0) begin
            n_errors++;
            $display("FAIL timeout_locked got=%0d want=0", lock_at_to);
        end
        n_checks++;
        if (if_b.timeout !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_level got=%b want=1", if_b.timeout);
        end
        ec2 = -1; to_at_e = -1; to_after = -1; n_pv = 0;
        v = ~v;
        for (int i = 0; i < 10; i++) begin
            clk_step(1'b0, v);
            if (ec2 >= 0 && cyc == ec2 + 1) to_after = int'(if_a.timeout);
            if (if_a.rise_pulse || if_a.fall_pulse) begin ec2 = cyc; to_at_e = int'(if_a.timeout); end
            if (if_a.period_valid || if_b.period_valid) n_pv++;
        end
        n_checks++;
        if (to_at_e != 1 || to_after != 0) begin
            n_errors++;
            $display("FAIL timeout_clear got=%0d%0d want=10", to_at_e, to_after);
        end
        n_checks++;
        if (n_pv != 0) begin
            n_errors++;
            $display("FAIL rearm_pv got=%0d want=0", n_pv);
        end
    endtask

    task automatic test_reset_mid();
        int n_pv;
        lock_up();
        n_checks++;
        if (if_a.locked !== 1'b1) begin
            n_errors++;
            $display("FAIL premid_locked got=%b want=1", if_a.locked);
        end
        clk_step(1'b0, 1'b1);
        clk_step(1'b1, 1'b1);
        n_checks++;
        if ({if_a.rise_pulse, if_a.fall_pulse, if_a.period_valid, if_a.locked, if_a.timeout,
             if_b.rise_pulse, if_b.fall_pulse, if_b.period_valid, if_b.locked, if_b.timeout} !== 10'b0
            || if_a.half_period !== CW'(0) || if_b.half_period !== CW'(0)) begin
            n_errors++;
            $display("FAIL midreset_outputs got=%b half=%0d want=0 half=0",
                     {if_a.rise_pulse, if_a.fall_pulse, if_a.period_valid, if_a.locked, if_a.timeout,
                      if_b.rise_pulse, if_b.fall_pulse, if_b.period_valid, if_b.locked, if_b.timeout},
                     if_a.half_period);
        end
        n_pv = 0;
        for (int i = 0; i < 6; i++) begin
            clk_step(1'b0, 1'b1);
            if (if_a.period_valid || if_b.period_valid) n_pv++;
        end
        n_checks++;
        if (n_pv != 0) begin
            n_errors++;
            $display("FAIL midreset_first_edge_pv got=%0d want=0", n_pv);
        end
    endtask

    task automatic test_random();
        int   steps, len, sel;
        logic v;
        logic [4:0] exp_f, got_a, got_b;
        steps = 0;
        v = sig_in;
        while (steps < 3000) begin
            sel = $urandom_range(0, 39);
            if (sel == 0) begin
                len = 1; v = 1'($urandom_range(0, 1));
            end else begin
                v = ~v;
                sel = $urandom_range(0, 9);
                if (sel < 7)      len = $urandom_range(4, 6);
                else if (sel < 9) len = $urandom_range(1, 3);
                else              len = $urandom_range(15, 26);
            end
            for (int j = 0; j < len; j++) begin
                clk_step(sel == 0 && len == 1 && j == 0 && steps % 2 == 0, v);
                steps++;
                exp_f = {p1 & ~p2, ~p1 & p2, m_pv, m_lock[0], m_to};
                got_a = {if_a.rise_pulse, if_a.fall_pulse, if_a.period_valid, if_a.locked, if_a.timeout};
                n_checks++;
                if (got_a !== exp_f) begin
                    n_errors++;
                    $display("FAIL rand_flags_a cyc=%0d got=%b want=%b", cyc, got_a, exp_f);
                end
                exp_f[1] = m_lock[1];
                got_b = {if_b.rise_pulse, if_b.fall_pulse, if_b.period_valid, if_b.locked, if_b.timeout};
                n_checks++;
                if (got_b !== exp_f) begin
                    n_errors++;
                    $display("FAIL rand_flags_b cyc=%0d got=%b want=%b", cyc, got_b, exp_f);
                end
                n_checks++;
                if (if_a.half_period !== CW'(m_half) || if_b.half_period !== CW'(m_half)) begin
                    n_errors++;
                    $display("FAIL rand_half cyc=%0d got=%0d/%0d want=%0d",
                             cyc, if_a.half_period, if_b.half_period, m_half);
                end
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        sig_in = 1'b0;
        test_reset();
        test_edge_latency();
        test_lock();
        test_unlock();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_period_monitor.md
CLK_PERIOD_MONITOR -- requirements
Module: clk_period_monitor

Interface
REQ-001 SHALL have parameter EXPECTED_HALF, default 1000, nominal sig_in half-period in clk cycles.
REQ-002 SHALL have parameter TOL, default 2, allowed absolute deviation from EXPECTED_HALF in cycles.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, consecutive matching measurements required to lock.
REQ-004 SHALL have parameter TIMEOUT_COUNT, default 4*EXPECTED_HALF, cycles without an edge before timeout.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port sig_in  input  1  asynchronous slow square wave (divided clock) to monitor.
REQ-008 SHALL have port rise_pulse  output  1  one-cycle strobe per synchronized rising edge.
REQ-009 SHALL have port fall_pulse  output  1  one-cycle strobe per synchronized falling edge.
REQ-010 SHALL have port half_period  output  CNT_W  last measured edge-to-edge interval in cycles, CNT_W = $clog2(TIMEOUT_COUNT+1).
REQ-011 SHALL have port period_valid  output  1  one-cycle strobe when half_period updates.
REQ-012 SHALL have port locked  output  1  level, high in LOCKED state.
REQ-013 SHALL have port timeout  output  1  level, high from timeout until next edge.

Function
REQ-014 sig_in SHALL pass through a two-flop synchronizer, then one history flop; edge = sync output differs from history.
REQ-015 A sig_in transition set up before clk edge k SHALL produce rise_pulse/fall_pulse high for exactly the cycle after edge k+1 (2-cycle latency).
REQ-016 Interval counter cnt SHALL load 1 in the cycle after an edge, else increment, saturating at TIMEOUT_COUNT.
REQ-017 On each edge cycle in MEASURE or LOCKED, half_period SHALL capture cnt and period_valid SHALL pulse the following cycle.
REQ-018 A measurement SHALL match when |half_period - EXPECTED_HALF| <= TOL, computed without wrap (unsigned compare of both orderings).
REQ-019 States SHALL be IDLE, MEASURE, LOCKED; IDLE->MEASURE on any edge, with no measurement and no period_valid.
REQ-020 MEASURE SHALL count consecutive matches; LOCK_COUNT-th match -> LOCKED; any mismatch clears the streak to 0.
REQ-021 LOCKED SHALL drop to MEASURE with streak 0 on a single mismatching measurement.
REQ-022 When cnt reaches TIMEOUT_COUNT with no edge, state SHALL go to IDLE, timeout SHALL set, streak SHALL clear.
REQ-023 An edge in the same cycle cnt would reach TIMEOUT_COUNT SHALL win: measurement taken, no timeout.
REQ-024 timeout SHALL clear in the cycle following the next edge; that edge only re-arms (IDLE->MEASURE).
REQ-025 half_period SHALL hold its last value through timeout and IDLE.

Reset
REQ-026 On reset: sync and history flops 0, cnt 0, streak 0, state IDLE, half_period 0, all strobes 0, locked 0, timeout 0.
REQ-027 Reset SHALL override every other event in the same cycle, including mid-measurement.
REQ-028 A spurious rise after reset, caused by sig_in being high, SHALL only arm MEASURE and SHALL NOT produce a measurement.

Structure
REQ-029 State enum (IDLE, MEASURE, LOCKED) SHALL live in shared package clk_monitor_pkg.
REQ-030 Two-flop synchronizer SHALL be sub-module sync_2ff with clk, reset, d, q.
REQ-031 Streak counter width SHALL be $clog2(LOCK_COUNT+1).

Verification
REQ-032 EXPECTED_HALF=5, TOL=0, LOCK_COUNT=4; sig_in toggles every 5 cycles -> half_period=5, locked rises after the 4th period_valid following arming.
REQ-033 Single sig_in high pulse lasting 3 cycles -> rise_pulse exactly 2 cycles after the transition, fall_pulse 3 cycles after rise_pulse.
REQ-034 Locked, then one half-period of 8 with EXPECTED_HALF=5, TOL=2 -> locked drops in the cycle after that measurement's period_valid; 4 further 5-cycle halves relock.
REQ-035 TIMEOUT_COUNT=20; sig_in held constant -> timeout high 20 cycles after the last edge, locked 0; next edge clears timeout and yields no period_valid.
REQ-036 Reset asserted mid-LOCKED with sig_in high -> all outputs 0 next cycle; after release, the first edge yields no period_valid.
